// File: rtl/scr1_dp_mem_arb.sv
// Port-B arbiter for the dual-port byte-enable SRAM.
// Requester 0 is the core data port, requester 1 the RLWE accelerator/DMA
// port. After reset the array is optionally zero-filled, then the two
// requesters share port B under round-robin arbitration with a fixed
// 1-cycle read latency.
module scr1_dp_mem_arb #(
   parameter int SCR1_WIDTH  = 32,
   parameter int SCR1_SIZE   = 32'h00010000,
   parameter int SCR1_NBYTES = SCR1_WIDTH/8,
   parameter int INIT_ZERO   = 1,
   localparam int AW         = $clog2(SCR1_SIZE) - 2
)(
   input  logic                   clk,
   input  logic                   rst,
   output logic                   init_done,

   input  logic                   r0_req,
   input  logic                   r0_we,
   input  logic [SCR1_NBYTES-1:0] r0_be,
   input  logic [AW-1:0]          r0_addr,
   input  logic [SCR1_WIDTH-1:0]  r0_wdata,
   output logic                   r0_gnt,
   output logic                   r0_rvalid,
   output logic [SCR1_WIDTH-1:0]  r0_rdata,

   input  logic                   r1_req,
   input  logic                   r1_we,
   input  logic [SCR1_NBYTES-1:0] r1_be,
   input  logic [AW-1:0]          r1_addr,
   input  logic [SCR1_WIDTH-1:0]  r1_wdata,
   output logic                   r1_gnt,
   output logic                   r1_rvalid,
   output logic [SCR1_WIDTH-1:0]  r1_rdata,

   output logic                   mem_renb,
   output logic                   mem_wenb,
   output logic [SCR1_NBYTES-1:0] mem_webb,
   output logic [AW-1:0]          mem_addrb,
   output logic [SCR1_WIDTH-1:0]  mem_datab,
   input  logic [SCR1_WIDTH-1:0]  mem_qb
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] cnt;
   logic          last_gnt;   // 1 = requester 1 was granted most recently
   logic          rv0;
   logic          rv1;

   // State register and zero-fill address counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Next state, round-robin grant and port-B drive; everything idles while rst is high
   always_comb begin
      state_next = state;
      init_done  = 1'b0;
      r0_gnt     = 1'b0;
      r1_gnt     = 1'b0;
      mem_renb   = 1'b0;
      mem_wenb   = 1'b0;
      mem_webb   = '0;
      mem_addrb  = '0;
      mem_datab  = '0;
      if (!rst) begin
         case (state)
            ST_INIT: begin
               mem_wenb  = 1'b1;
               mem_webb  = '1;
               mem_addrb = cnt;
               if (cnt == '1) begin
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               init_done = 1'b1;
               if (r0_req && (!r1_req || last_gnt)) begin
                  r0_gnt = 1'b1;
               end else if (r1_req) begin
                  r1_gnt = 1'b1;
               end
               if (r0_gnt) begin
                  mem_addrb = r0_addr;
                  mem_datab = r0_wdata;
                  mem_wenb  = r0_we;
                  mem_renb  = !r0_we;
                  mem_webb  = r0_we ? r0_be : '0;
               end else if (r1_gnt) begin
                  mem_addrb = r1_addr;
                  mem_datab = r1_wdata;
                  mem_wenb  = r1_we;
                  mem_renb  = !r1_we;
                  mem_webb  = r1_we ? r1_be : '0;
               end
            end
            default: state_next = ST_RUN;
         endcase
      end
   end

   // Round-robin history and read-response valid flags
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
         rv0      <= 1'b0;
         rv1      <= 1'b0;
      end else begin
         if (r0_gnt) begin
            last_gnt <= 1'b0;
         end else if (r1_gnt) begin
            last_gnt <= 1'b1;
         end
         rv0 <= r0_gnt && !r0_we;
         rv1 <= r1_gnt && !r1_we;
      end
   end

   // Read data is steered to the port that issued the read, zero otherwise
   always_comb begin
      r0_rvalid = rv0;
      r1_rvalid = rv1;
      r0_rdata  = rv0 ? mem_qb : '0;
      r1_rdata  = rv1 ? mem_qb : '0;
   end

endmodule

// File: tb/tb_scr1_dp_mem_arb.sv
// Self-checking bench for scr1_dp_mem_arb: directed zero-fill, write/read,
// byte-enable, contention and mid-fill reset steps on a 16-word instance,
// a randomized phase against a behavioural memory/arbitration model, and a
// short check of an instance built without zero-fill.
module tb_scr1_dp_mem_arb;
   localparam int NW = 16;
   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance A: zero-fill enabled ----------------
   logic        a_rst, a_init_done;
   logic        a_r0_req, a_r0_we, a_r0_gnt, a_r0_rvalid;
   logic [3:0]  a_r0_be, a_r0_addr;
   logic [31:0] a_r0_wdata, a_r0_rdata;
   logic        a_r1_req, a_r1_we, a_r1_gnt, a_r1_rvalid;
   logic [3:0]  a_r1_be, a_r1_addr;
   logic [31:0] a_r1_wdata, a_r1_rdata;
   logic        a_renb, a_wenb;
   logic [3:0]  a_webb, a_addrb;
   logic [31:0] a_datab;
   logic [31:0] a_qb = '0;

   scr1_dp_mem_arb #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .INIT_ZERO(1)) dut_a (
      .clk(clk), .rst(a_rst), .init_done(a_init_done),
      .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_be(a_r0_be), .r0_addr(a_r0_addr),
      .r0_wdata(a_r0_wdata), .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid), .r0_rdata(a_r0_rdata),
      .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_be(a_r1_be), .r1_addr(a_r1_addr),
      .r1_wdata(a_r1_wdata), .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid), .r1_rdata(a_r1_rdata),
      .mem_renb(a_renb), .mem_wenb(a_wenb), .mem_webb(a_webb), .mem_addrb(a_addrb),
      .mem_datab(a_datab), .mem_qb(a_qb)
   );

   // ---------------- instance B: zero-fill disabled ----------------
   logic        b_rst, b_init_done;
   logic        b_r0_req, b_r0_we, b_r0_gnt, b_r0_rvalid;
   logic [3:0]  b_r0_be, b_r0_addr;
   logic [31:0] b_r0_wdata, b_r0_rdata;
   logic        b_r1_gnt, b_r1_rvalid;
   logic [31:0] b_r1_rdata;
   logic        b_renb, b_wenb;
   logic [3:0]  b_webb, b_addrb;
   logic [31:0] b_datab;
   logic [31:0] b_qb = '0;
   logic        b_r1_req = 1'b0;
   logic        b_r1_we = 1'b0;
   logic [3:0]  b_r1_be = '0;
   logic [3:0]  b_r1_addr = '0;
   logic [31:0] b_r1_wdata = '0;

   scr1_dp_mem_arb #(.SCR1_WIDTH(32), .SCR1_SIZE(64), .INIT_ZERO(0)) dut_b (
      .clk(clk), .rst(b_rst), .init_done(b_init_done),
      .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_be(b_r0_be), .r0_addr(b_r0_addr),
      .r0_wdata(b_r0_wdata), .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
      .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_be(b_r1_be), .r1_addr(b_r1_addr),
      .r1_wdata(b_r1_wdata), .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
      .mem_renb(b_renb), .mem_wenb(b_wenb), .mem_webb(b_webb), .mem_addrb(b_addrb),
      .mem_datab(b_datab), .mem_qb(b_qb)
   );

   // ---------------- SRAM port-B models (seeded with non-zero junk) ----------------
   logic [31:0] a_mem [NW];
   logic [31:0] b_mem [NW];
   bit          seeded = 1'b0;

   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < NW; i++) begin
            a_mem[i] <= $urandom | 32'h0000_0001;
            b_mem[i] <= 32'hC0FFEE00 + i;
         end
         seeded <= 1'b1;
      end else begin
         if (a_wenb)
            for (int j = 0; j < NB; j++)
               if (a_webb[j]) a_mem[a_addrb][8*j +: 8] <= a_datab[8*j +: 8];
         if (a_renb) a_qb <= a_mem[a_addrb];
         if (b_wenb)
            for (int j = 0; j < NB; j++)
               if (b_webb[j]) b_mem[b_addrb][8*j +: 8] <= b_datab[8*j +: 8];
         if (b_renb) b_qb <= b_mem[b_addrb];
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drv0(input logic req, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] d);
      a_r0_req = req; a_r0_we = we; a_r0_be = be; a_r0_addr = addr; a_r0_wdata = d;
   endtask

   task automatic drv1(input logic req, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] d);
      a_r1_req = req; a_r1_we = we; a_r1_be = be; a_r1_addr = addr; a_r1_wdata = d;
   endtask

   task automatic fill_step(input int k);
      chk1("fill_init_done", a_init_done, 1'b0);
      chk1("fill_wenb", a_wenb, 1'b1);
      chk1("fill_renb", a_renb, 1'b0);
      chk("fill_webb", 32'(a_webb), 32'hF);
      chk("fill_addr", 32'(a_addrb), k);
      chk("fill_data", a_datab, 32'h0);
      chk1("fill_gnt0", a_r0_gnt, 1'b0);
      chk1("fill_gnt1", a_r1_gnt, 1'b0);
   endtask

   task automatic reset_state();
      chk1("rst_init_done", a_init_done, 1'b0);
      chk1("rst_gnt0", a_r0_gnt, 1'b0);
      chk1("rst_gnt1", a_r1_gnt, 1'b0);
      chk1("rst_rvalid0", a_r0_rvalid, 1'b0);
      chk1("rst_rvalid1", a_r1_rvalid, 1'b0);
      chk("rst_rdata0", a_r0_rdata, 32'h0);
      chk("rst_rdata1", a_r1_rdata, 32'h0);
      chk1("rst_renb", a_renb, 1'b0);
      chk1("rst_wenb", a_wenb, 1'b0);
   endtask

   // ---------------- reference model state for the random phase ----------------
   logic [31:0] mdl [NW];
   logic        last;                       // 1 = requester 1 won the last grant
   logic        p0, p0_we, p1, p1_we;
   logic [3:0]  p0_be, p0_addr, p1_be, p1_addr;
   logic [31:0] p0_data, p1_data;
   logic        v0, v1, nv0, nv1, gw;
   logic [31:0] d0, d1, nd0, nd1, gd;
   logic [3:0]  ga, gb;
   int          g;

   initial begin
      a_rst = 1'b1; b_rst = 1'b1;
      drv0(0, 0, 4'h0, 4'h0, 32'h0);
      drv1(0, 0, 4'h0, 4'h0, 32'h0);
      b_r0_req = 1'b0; b_r0_we = 1'b0; b_r0_be = '0; b_r0_addr = '0; b_r0_wdata = '0;

      // reset state
      repeat (3) next_cycle();
      sample();
      reset_state();

      // zero-fill with r0 read of address 5 held pending
      next_cycle();
      a_rst = 1'b0;
      drv0(1, 0, 4'hF, 4'd5, 32'h0);
      for (int k = 0; k < NW; k++) begin
         if (k > 0) next_cycle();
         sample();
         fill_step(k);
      end
      next_cycle();
      sample();
      chk1("run_init_done", a_init_done, 1'b1);
      chk1("zf_gnt0", a_r0_gnt, 1'b1);
      chk1("zf_renb", a_renb, 1'b1);
      chk("zf_addr", 32'(a_addrb), 32'd5);
      next_cycle();
      drv0(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("zf_rvalid0", a_r0_rvalid, 1'b1);
      chk("zf_rdata0", a_r0_rdata, 32'h0);

      // r0 write then read of address 3
      next_cycle();
      drv0(1, 1, 4'hF, 4'd3, 32'hDEADBEEF);
      sample();
      chk1("wr_gnt0", a_r0_gnt, 1'b1);
      chk1("wr_wenb", a_wenb, 1'b1);
      chk1("wr_renb", a_renb, 1'b0);
      chk("wr_webb", 32'(a_webb), 32'hF);
      chk("wr_addr", 32'(a_addrb), 32'd3);
      chk("wr_data", a_datab, 32'hDEADBEEF);
      next_cycle();
      drv0(1, 0, 4'hF, 4'd3, 32'h0);
      sample();
      chk1("rd_gnt0", a_r0_gnt, 1'b1);
      chk1("rd_renb", a_renb, 1'b1);
      chk1("rd_wenb", a_wenb, 1'b0);
      chk("rd_webb", 32'(a_webb), 32'h0);
      chk1("rd_rvalid_early", a_r0_rvalid, 1'b0);
      next_cycle();
      drv0(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("rd_rvalid0", a_r0_rvalid, 1'b1);
      chk("rd_rdata0", a_r0_rdata, 32'hDEADBEEF);
      chk1("rd_rvalid1", a_r1_rvalid, 1'b0);

      // byte enables through r1
      next_cycle();
      drv1(1, 1, 4'hF, 4'd7, 32'hAABBCCDD);
      sample();
      chk1("be_gnt1_a", a_r1_gnt, 1'b1);
      next_cycle();
      drv1(1, 1, 4'b0101, 4'd7, 32'h11223344);
      sample();
      chk1("be_gnt1_b", a_r1_gnt, 1'b1);
      chk("be_webb", 32'(a_webb), 32'h5);
      next_cycle();
      drv1(1, 0, 4'h0, 4'd7, 32'h0);
      sample();
      chk1("be_rd_gnt1", a_r1_gnt, 1'b1);
      next_cycle();
      drv1(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("be_rvalid1", a_r1_rvalid, 1'b1);
      chk("be_rdata1", a_r1_rdata, 32'hAA22CC44);
      chk1("be_rvalid0", a_r0_rvalid, 1'b0);
      chk("be_rdata0", a_r0_rdata, 32'h0);

      // reset, then a reset mid-fill at address 9
      next_cycle();
      a_rst = 1'b1;
      next_cycle();
      sample();
      reset_state();
      next_cycle();
      a_rst = 1'b0;
      drv0(1, 0, 4'h0, 4'd1, 32'h0);
      drv1(1, 0, 4'h0, 4'd2, 32'h0);
      for (int k = 0; k < 9; k++) begin
         if (k > 0) next_cycle();
         sample();
         chk("mid_addr", 32'(a_addrb), k);
         chk1("mid_wenb", a_wenb, 1'b1);
      end
      next_cycle();
      a_rst = 1'b1;
      sample();
      chk1("mid_rst_wenb", a_wenb, 1'b0);
      chk1("mid_rst_init_done", a_init_done, 1'b0);
      next_cycle();
      a_rst = 1'b0;
      for (int k = 0; k < NW; k++) begin
         if (k > 0) next_cycle();
         sample();
         fill_step(k);
      end

      // contention: both held, grants r0, r1, r0, r1
      next_cycle();
      sample();
      chk1("ct_init_done", a_init_done, 1'b1);
      chk1("ct1_gnt0", a_r0_gnt, 1'b1);
      chk1("ct1_gnt1", a_r1_gnt, 1'b0);
      chk("ct1_addr", 32'(a_addrb), 32'd1);
      next_cycle();
      drv0(1, 0, 4'h0, 4'd3, 32'h0);
      sample();
      chk1("ct2_gnt0", a_r0_gnt, 1'b0);
      chk1("ct2_gnt1", a_r1_gnt, 1'b1);
      chk("ct2_addr", 32'(a_addrb), 32'd2);
      chk1("ct2_rv0", a_r0_rvalid, 1'b1);
      chk1("ct2_rv1", a_r1_rvalid, 1'b0);
      next_cycle();
      drv1(1, 0, 4'h0, 4'd4, 32'h0);
      sample();
      chk1("ct3_gnt0", a_r0_gnt, 1'b1);
      chk1("ct3_gnt1", a_r1_gnt, 1'b0);
      chk("ct3_addr", 32'(a_addrb), 32'd3);
      chk1("ct3_rv0", a_r0_rvalid, 1'b0);
      chk1("ct3_rv1", a_r1_rvalid, 1'b1);
      next_cycle();
      drv0(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("ct4_gnt0", a_r0_gnt, 1'b0);
      chk1("ct4_gnt1", a_r1_gnt, 1'b1);
      chk("ct4_addr", 32'(a_addrb), 32'd4);
      chk1("ct4_rv0", a_r0_rvalid, 1'b1);
      chk1("ct4_rv1", a_r1_rvalid, 1'b0);
      next_cycle();
      drv1(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("ct5_rv0", a_r0_rvalid, 1'b0);
      chk1("ct5_rv1", a_r1_rvalid, 1'b1);
      chk("ct5_rdata1", a_r1_rdata, 32'h0);

      // randomized traffic against the reference model (memory is all zero after fill)
      for (int i = 0; i < NW; i++) mdl[i] = '0;
      last = 1'b1;
      p0 = 1'b0; p1 = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
      p0_we = 1'b0; p0_be = '0; p0_addr = '0; p0_data = '0;
      p1_we = 1'b0; p1_be = '0; p1_addr = '0; p1_data = '0;
      for (int n = 0; n < 400; n++) begin
         next_cycle();
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1'b1; p0_we = 1'($urandom_range(0, 1)); p0_be = 4'($urandom_range(0, 15));
            p0_addr = 4'($urandom_range(0, 3)); p0_data = $urandom;
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1; p1_we = 1'($urandom_range(0, 1)); p1_be = 4'($urandom_range(0, 15));
            p1_addr = 4'($urandom_range(0, 3)); p1_data = $urandom;
         end
         drv0(p0, p0_we, p0_be, p0_addr, p0_data);
         drv1(p1, p1_we, p1_be, p1_addr, p1_data);
         if (p0 && p1) g = last ? 0 : 1;
         else if (p0)  g = 0;
         else if (p1)  g = 1;
         else          g = -1;
         sample();
         chk1("rnd_gnt0", a_r0_gnt, g == 0);
         chk1("rnd_gnt1", a_r1_gnt, g == 1);
         chk1("rnd_rv0", a_r0_rvalid, v0);
         chk("rnd_rdata0", a_r0_rdata, v0 ? d0 : 32'h0);
         chk1("rnd_rv1", a_r1_rvalid, v1);
         chk("rnd_rdata1", a_r1_rdata, v1 ? d1 : 32'h0);
         nv0 = 1'b0; nv1 = 1'b0; nd0 = '0; nd1 = '0;
         gw = 1'b0; ga = '0; gb = '0; gd = '0;
         if (g == 0) begin
            gw = p0_we; ga = p0_addr; gb = p0_be; gd = p0_data; p0 = 1'b0; last = 1'b0;
         end else if (g == 1) begin
            gw = p1_we; ga = p1_addr; gb = p1_be; gd = p1_data; p1 = 1'b0; last = 1'b1;
         end
         if (g >= 0) begin
            chk1("rnd_wenb", a_wenb, gw);
            chk1("rnd_renb", a_renb, !gw);
            chk("rnd_addr", 32'(a_addrb), 32'(ga));
            if (gw) begin
               chk("rnd_wdata", a_datab, gd);
               chk("rnd_webb", 32'(a_webb), 32'(gb));
               for (int j = 0; j < NB; j++)
                  if (gb[j]) mdl[ga][8*j +: 8] = gd[8*j +: 8];
            end else if (g == 0) begin
               nv0 = 1'b1; nd0 = mdl[ga];
            end else begin
               nv1 = 1'b1; nd1 = mdl[ga];
            end
         end else begin
            chk1("rnd_idle_wenb", a_wenb, 1'b0);
            chk1("rnd_idle_renb", a_renb, 1'b0);
         end
         v0 = nv0; d0 = nd0; v1 = nv1; d1 = nd1;
      end
      next_cycle();
      drv0(0, 0, 4'h0, 4'h0, 32'h0);
      drv1(0, 0, 4'h0, 4'h0, 32'h0);
      sample();
      chk1("rnd_end_rv0", a_r0_rvalid, v0);
      chk("rnd_end_rdata0", a_r0_rdata, v0 ? d0 : 32'h0);
      chk1("rnd_end_rv1", a_r1_rvalid, v1);
      chk("rnd_end_rdata1", a_r1_rdata, v1 ? d1 : 32'h0);

      // instance without zero-fill
      chk1("nz_rst_init_done", b_init_done, 1'b0);
      chk1("nz_rst_wenb", b_wenb, 1'b0);
      chk1("nz_rst_rvalid", b_r0_rvalid, 1'b0);
      next_cycle();
      b_rst = 1'b0;
      sample();
      chk1("nz_init_done", b_init_done, 1'b1);
      chk1("nz_wenb0", b_wenb, 1'b0);
      chk1("nz_renb0", b_renb, 1'b0);
      next_cycle();
      sample();
      chk1("nz_wenb1", b_wenb, 1'b0);
      next_cycle();
      b_r0_req = 1'b1; b_r0_we = 1'b0; b_r0_addr = 4'd0;
      sample();
      chk1("nz_gnt0", b_r0_gnt, 1'b1);
      chk1("nz_renb", b_renb, 1'b1);
      chk("nz_addr", 32'(b_addrb), 32'd0);
      next_cycle();
      b_r0_req = 1'b0;
      sample();
      chk1("nz_rvalid0", b_r0_rvalid, 1'b1);
      chk("nz_rdata0", b_r0_rdata, 32'hC0FFEE00);
      chk1("nz_rvalid1", b_r1_rvalid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scr1_dp_mem_arb.md
Name: scr1_dp_mem_arb

Overview:
- Shares port B of the dual-port byte-enable SRAM between two requesters:
  - requester 0: core data port;
  - requester 1: RLWE accelerator/DMA data port.
- Port A (instruction fetch) stays connected directly to the memory and is outside this block.
- After reset, an optional zero-fill sequence clears the whole array.
- After zero-fill, requests are served by round-robin arbitration with a fixed 1-cycle read latency.

Parameters:
- SCR1_WIDTH, 32, data width in bits.
- SCR1_SIZE, 32'h00010000, memory size in bytes.
- SCR1_NBYTES, SCR1_WIDTH/8, byte lanes.
- INIT_ZERO, 1, 1 = zero-fill the array after reset; 0 = skip zero-fill.
- AW (local), $clog2(SCR1_SIZE)-2, word address width.

Ports:
- clk  in  1  single clock for the block and the memory.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once zero-fill is complete and arbitration is running.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  1 = write, 0 = read.
- r0_be  in  SCR1_NBYTES  write byte enables.
- r0_addr  in  AW  word address.
- r0_wdata  in  SCR1_WIDTH  write data.
- r0_gnt  out  1  request accepted this cycle.
- r0_rvalid  out  1  read data valid.
- r0_rdata  out  SCR1_WIDTH  read data.
- r1_*  same set as r0_* for requester 1.
- mem_renb  out  1  memory port B read enable.
- mem_wenb  out  1  memory port B write enable.
- mem_webb  out  SCR1_NBYTES  memory port B byte enables.
- mem_addrb  out  AW  memory port B address.
- mem_datab  out  SCR1_WIDTH  memory port B write data.
- mem_qb  in  SCR1_WIDTH  memory port B read data, valid one cycle after mem_renb.

Behaviour:

Reset:
- While rst is high:
  - FSM goes to INIT (INIT_ZERO=1) or RUN (INIT_ZERO=0);
  - init counter = 0;
  - last_gnt = 1, so r0 wins the first conflict;
  - rvalid flops = 0.
- Output values during and right after reset:
  - init_done = 0, all gnt = 0, all rvalid = 0, all rdata = 0;
  - mem_renb = mem_wenb = 0.

FSM, states INIT and RUN:
- INIT, one write per cycle:
  - mem_wenb = 1, mem_webb = all ones, mem_addrb = counter, mem_datab = 0.
  - The counter increments every cycle.
  - On the cycle writing address 2^AW-1, the FSM moves to RUN.
  - Zero-fill therefore takes exactly 2^AW cycles.
- INIT, requesters:
  - All gnt are 0; requests stay pending (requesters must hold them).
  - mem_renb = 0.
- RUN:
  - init_done = 1.
  - No return to INIT except through rst.
  - A reset asserted mid-INIT restarts the fill from address 0.

Arbitration in RUN (combinational grant, same cycle as the request):
- Only r0_req set: grant r0.
- Only r1_req set: grant r1.
- Both set: grant the requester that is not last_gnt.
- last_gnt updates on every grant.
- At most one gnt per cycle.
- A requester must hold req, we, be, addr and wdata stable until it sees gnt.

Memory drive in RUN:
- The granted requester's addr, wdata and be are routed to the memory.
- Write grant: mem_wenb = 1, mem_webb = be & {NBYTES{1}}, mem_renb = 0.
- Read grant: mem_renb = 1, mem_wenb = 0, mem_webb = 0.
- No grant: mem_renb = mem_wenb = 0.
- Address and data fields are don't-care when the corresponding enable is low.

Response:
- A read granted in cycle N gives rX_rvalid = 1 in cycle N+1 with rX_rdata = mem_qb.
- rdata is forced to 0 when rvalid = 0.
- Writes complete at grant and produce no rvalid.
- Back-to-back reads give one response per cycle; there is no other buffering.

Ordering:
- A write granted in N followed by a read of the same address granted in N+1 returns the new data in N+2.
- This holds across requesters.

Test Plan:
- Zero-fill, SCR1_SIZE=64 (16 words): release rst with r0_req held high.
  - init_done rises after exactly 16 cycles.
  - mem_wenb is high for 16 cycles on addresses 0..15 with data 0.
  - r0_gnt stays 0 until RUN.
  - Then read address 5 and get rdata = 0.
- Single requester, write then read: r0 writes address 3, data 32'hDEADBEEF, be = 4'b1111; next cycle r0 reads address 3.
  - r0_rvalid = 1 two cycles after the write grant, with r0_rdata = 32'hDEADBEEF.
- Byte enables: r1 writes 32'h11223344 with be = 4'b0101 over 32'hAABBCCDD at address 7; then read address 7.
  - Read returns 32'hAA22CC44.
- Contention: r0_req and r1_req both held high for 4 consecutive reads after reset.
  - Grants go r0, r1, r0, r1.
  - Each rvalid follows its grant by 1 cycle on the correct port only.
- Reset mid-INIT: assert rst for 1 cycle at fill address 9.
  - The fill restarts at address 0.
  - init_done rises 16 cycles after rst deasserts.
- INIT_ZERO=0: init_done = 1 on the first cycle after reset, and no memory write occurs without a request.
  - A read of address 0 granted the same cycle gives rvalid in the next cycle.
